// File: rtl/float_normalize_pkg.sv
// Shared float format parameters and the normaliser state encoding.
package float_params;

   localparam int float_width      = 32;
   localparam int float_exp_width  = 8;
   localparam int float_mant_width = 23;

   // All-ones exponent marks infinity/NaN.
   localparam logic [float_exp_width-1:0] float_exp_max = {float_exp_width{1'b1}};
   localparam logic [float_exp_width-1:0] float_exp_one = {{(float_exp_width-1){1'b0}}, 1'b1};

   typedef enum logic {
      IDLE = 1'b0,
      NORM = 1'b1
   } state_t;

endpackage

// File: rtl/float_normalize.sv
// Normalisation stage behind the float adder: takes {sign, exp, carry.hidden.fraction}
// and emits a packed float. Cancellation is resolved one left shift per cycle.
//
// Handshake: req is a start pulse, sampled only on a clock edge where busy=0;
// busy stays high from the cycle after acceptance up to the ack cycle.
// ack is a one-cycle pulse and out is valid in that cycle, then holds.
// A req seen while busy=1 is dropped.
module float_normalize
   import float_params::*;
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        req,
   input  logic                        in_sign,
   input  logic [float_exp_width-1:0]  in_exp,
   input  logic [float_mant_width+1:0] in_mant,
   output logic                        busy,
   output logic                        ack,
   output logic [float_width-1:0]      out
);

   localparam int mw = float_mant_width;

   state_t                        state_r, state_d;
   logic                          sign_r, sign_d;
   logic [float_exp_width-1:0]    exp_r, exp_d;
   logic [mw+1:0]                 mant_r, mant_d;
   logic                          ack_d;
   logic [float_width-1:0]        out_d;

   // Carry path: one right shift with matching exponent increment.
   logic [mw+1:0]                 carry_mant;
   logic [float_exp_width-1:0]    carry_exp;

   assign carry_mant = mant_r >> 1;
   assign carry_exp  = exp_r + float_exp_one;
   assign busy       = (state_r == NORM);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_r <= IDLE;
      else     state_r <= state_d;
   end

   // Datapath, ack and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         sign_r <= 1'b0;
         exp_r  <= '0;
         mant_r <= '0;
         ack    <= 1'b0;
         out    <= '0;
      end else begin
         sign_r <= sign_d;
         exp_r  <= exp_d;
         mant_r <= mant_d;
         ack    <= ack_d;
         out    <= out_d;
      end
   end

   // Next state and one normalisation rule per cycle, first match wins.
   always_comb begin
      state_d = state_r;
      sign_d  = sign_r;
      exp_d   = exp_r;
      mant_d  = mant_r;
      ack_d   = 1'b0;
      out_d   = out;
      unique case (state_r)
         IDLE: begin
            if (req) begin
               sign_d  = in_sign;
               exp_d   = in_exp;
               mant_d  = in_mant;
               state_d = NORM;
            end
         end
         NORM: begin
            if (exp_r == float_exp_max) begin
               // Infinity/NaN passes through with its fraction.
               out_d   = {sign_r, float_exp_max, mant_r[mw-1:0]};
               ack_d   = 1'b1;
               state_d = IDLE;
            end else if (mant_r == '0) begin
               // Exact zero is always +0.
               out_d   = '0;
               ack_d   = 1'b1;
               state_d = IDLE;
            end else if (mant_r[mw+1]) begin
               // Carry-out: truncate one bit; may overflow to infinity.
               if (carry_exp == float_exp_max)
                  out_d = {sign_r, float_exp_max, {mw{1'b0}}};
               else
                  out_d = {sign_r, carry_exp, carry_mant[mw-1:0]};
               ack_d   = 1'b1;
               state_d = IDLE;
            end else if (mant_r[mw]) begin
               out_d   = {sign_r, exp_r, mant_r[mw-1:0]};
               ack_d   = 1'b1;
               state_d = IDLE;
            end else if (exp_r <= float_exp_one) begin
               // No exponent left to borrow: flush to signed zero.
               out_d   = {sign_r, {(float_width-1){1'b0}}};
               ack_d   = 1'b1;
               state_d = IDLE;
            end else begin
               mant_d  = mant_r << 1;
               exp_d   = exp_r - float_exp_one;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
